// File: rtl/display_scan_decoder_if.sv
// Scanned 7-segment display bus: the scan side drives anode/segment and the
// decoder side returns the reassembled minute/second frame and status pulses.
`default_nettype none

interface display_scan_decoder_if #(
  parameter int ERRCNT_W = 8
);
  logic [3:0]          anode;
  logic [6:0]          segment;
  logic [5:0]          mincount;
  logic [5:0]          seccount;
  logic                min_blank;
  logic                sec_blank;
  logic                frame_valid;
  logic                frame_err;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    output anode,
    output segment,
    input  mincount,
    input  seccount,
    input  min_blank,
    input  sec_blank,
    input  frame_valid,
    input  frame_err,
    input  err_count
  );

  modport slave (
    input  anode,
    input  segment,
    output mincount,
    output seccount,
    output min_blank,
    output sec_blank,
    output frame_valid,
    output frame_err,
    output err_count
  );
endinterface

`default_nettype wire

// File: rtl/display_scan_decoder.sv
// Samples a multiplexed 4-digit 7-segment scan, reassembles MM:SS frames,
// publishes good frames and counts discarded ones.
`default_nettype none

module display_scan_decoder #(
  parameter int ERRCNT_W = 8
) (
  input  logic                   fastclk,
  input  logic                   rst_n,
  display_scan_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    D1   = 2'd1,
    D2   = 2'd2,
    D3   = 2'd3
  } state_t;

  // Digit codes: 0..9 numeric, plus blank and illegal-pattern markers.
  localparam logic [3:0] C_BLANK = 4'd10;
  localparam logic [3:0] C_BAD   = 4'd15;

  state_t              state_q, state_d;
  logic [3:0]          d0_q, d0_d;
  logic [3:0]          d1_q, d1_d;
  logic [3:0]          d2_q, d2_d;
  logic [5:0]          min_q, min_d;
  logic [5:0]          sec_q, sec_d;
  logic                minb_q, minb_d;
  logic                secb_q, secb_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  logic [3:0] code;
  logic [1:0] idx;
  logic       an_ok;
  logic       legal;

  logic       min_num, min_blk, min_good;
  logic       sec_num, sec_blk, sec_good;
  logic [6:0] min_val, sec_val;

  always_comb begin
    code = C_BAD;
    unique case (bus.segment)
      7'b0000001: code = 4'd0;
      7'b1001111: code = 4'd1;
      7'b0010010: code = 4'd2;
      7'b0000110: code = 4'd3;
      7'b1001100: code = 4'd4;
      7'b0100100: code = 4'd5;
      7'b0100000: code = 4'd6;
      7'b0001111: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0000100: code = 4'd9;
      7'b1111111: code = C_BLANK;
      default:    code = C_BAD;
    endcase
  end

  always_comb begin
    idx   = 2'd0;
    an_ok = 1'b1;
    unique case (bus.anode)
      4'b0111: idx = 2'd0;
      4'b1011: idx = 2'd1;
      4'b1101: idx = 2'd2;
      4'b1110: idx = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  assign legal = an_ok && (code != C_BAD);

  // Pair checks use the current sample as the seconds-ones digit.
  always_comb begin
    min_num  = (d0_q < 4'd10) && (d1_q < 4'd10);
    min_blk  = (d0_q == C_BLANK) && (d1_q == C_BLANK);
    min_val  = {3'b000, d0_q} * 7'd10 + {3'b000, d1_q};
    min_good = min_blk || (min_num && (min_val <= 7'd59));
    sec_num  = (d2_q < 4'd10) && (code < 4'd10);
    sec_blk  = (d2_q == C_BLANK) && (code == C_BLANK);
    sec_val  = {3'b000, d2_q} * 7'd10 + {3'b000, code};
    sec_good = sec_blk || (sec_num && (sec_val <= 7'd59));
  end

  always_comb begin
    state_d = state_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    min_d   = min_q;
    sec_d   = sec_q;
    minb_d  = minb_q;
    secb_d  = secb_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (state_q == HUNT) begin
      if (legal && (idx == 2'd0)) begin
        d0_d    = code;
        state_d = D1;
      end
    end else if (legal && (idx == state_q)) begin
      unique case (state_q)
        D1: begin
          d1_d    = code;
          state_d = D2;
        end
        D2: begin
          d2_d    = code;
          state_d = D3;
        end
        default: begin
          state_d = HUNT;
          if (min_good && sec_good) begin
            valid_d = 1'b1;
            minb_d  = min_blk;
            secb_d  = sec_blk;
            if (!min_blk) min_d = min_val[5:0];
            if (!sec_blk) sec_d = sec_val[5:0];
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (legal && (idx == 2'd0)) begin
      err_d   = 1'b1;
      d0_d    = code;
      state_d = D1;
    end else begin
      err_d   = 1'b1;
      state_d = HUNT;
    end
  end

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_d && (errcnt_q != {ERRCNT_W{1'b1}})) begin
      errcnt_d = errcnt_q + 1'b1;
    end
  end

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      d0_q     <= 4'd0;
      d1_q     <= 4'd0;
      d2_q     <= 4'd0;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      minb_q   <= 1'b0;
      secb_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      minb_q   <= minb_d;
      secb_q   <= secb_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign bus.mincount    = min_q;
  assign bus.seccount    = sec_q;
  assign bus.min_blank   = minb_q;
  assign bus.sec_blank   = secb_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;
  assign bus.err_count   = errcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder, with a narrow-counter instance
// for saturation.
`default_nettype none

module tb_display_scan_decoder;

  logic fastclk = 1'b0;
  logic rst_n   = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 fastclk = ~fastclk;

  display_scan_decoder_if #(.ERRCNT_W(8)) bus ();
  display_scan_decoder_if #(.ERRCNT_W(2)) bus_s ();

  display_scan_decoder #(.ERRCNT_W(8)) dut (
    .fastclk (fastclk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  display_scan_decoder #(.ERRCNT_W(2)) dut_s (
    .fastclk (fastclk),
    .rst_n   (rst_n),
    .bus     (bus_s)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int i);
    case (i)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      3:       return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  // Present one sample, let the edge take it, then settle 1 time unit.
  task automatic step(input int i, input logic [6:0] seg);
    bus.anode   = an_of(i);
    bus.segment = seg;
    @(posedge fastclk);
    #1;
  endtask

  task automatic step_s(input int i, input logic [6:0] seg);
    bus_s.anode   = an_of(i);
    bus_s.segment = seg;
    @(posedge fastclk);
    #1;
  endtask

  task automatic frame(input int a, input int b, input int c, input int d);
    step(0, seg_of(a));
    step(1, seg_of(b));
    step(2, seg_of(c));
    step(3, seg_of(d));
  endtask

  task automatic test_reset();
    bus.anode     = 4'b1111;
    bus.segment   = 7'b1111111;
    bus_s.anode   = 4'b1111;
    bus_s.segment = 7'b1111111;
    rst_n = 1'b0;
    repeat (3) @(posedge fastclk);
    #1;
    rst_n = 1'b1;
    total++; if (bus.mincount !== 6'd0) begin $display("FAIL reset_min got=%0d exp=0", bus.mincount); bad++; end
    total++; if (bus.seccount !== 6'd0) begin $display("FAIL reset_sec got=%0d exp=0", bus.seccount); bad++; end
    total++; if ({bus.min_blank, bus.sec_blank} !== 2'b00) begin $display("FAIL reset_blank got=%b exp=00", {bus.min_blank, bus.sec_blank}); bad++; end
    total++; if ({bus.frame_valid, bus.frame_err} !== 2'b00) begin $display("FAIL reset_pulses got=%b exp=00", {bus.frame_valid, bus.frame_err}); bad++; end
    total++; if (bus.err_count !== 8'd0) begin $display("FAIL reset_errcnt got=%0d exp=0", bus.err_count); bad++; end
  endtask

  task automatic test_nominal();
    int dg[4] = '{1, 2, 3, 4};
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        step(k, seg_of(dg[k]));
        total++;
        if (bus.frame_valid !== (k == 3)) begin
          $display("FAIL nominal_valid frame=%0d digit=%0d got=%b exp=%b", f, k, bus.frame_valid, (k == 3)); bad++;
        end
        total++;
        if (bus.frame_err !== 1'b0) begin $display("FAIL nominal_err frame=%0d digit=%0d got=%b exp=0", f, k, bus.frame_err); bad++; end
      end
    end
    total++; if (bus.mincount !== 6'd12) begin $display("FAIL nominal_min got=%0d exp=12", bus.mincount); bad++; end
    total++; if (bus.seccount !== 6'd34) begin $display("FAIL nominal_sec got=%0d exp=34", bus.seccount); bad++; end
    total++; if ({bus.min_blank, bus.sec_blank} !== 2'b00) begin $display("FAIL nominal_blank got=%b exp=00", {bus.min_blank, bus.sec_blank}); bad++; end
    total++; if (bus.err_count !== 8'd0) begin $display("FAIL nominal_errcnt got=%0d exp=0", bus.err_count); bad++; end
  endtask

  task automatic test_blink();
    frame(10, 10, 0, 5);
    total++; if (bus.frame_valid !== 1'b1) begin $display("FAIL blink_valid got=%b exp=1", bus.frame_valid); bad++; end
    total++; if (bus.min_blank !== 1'b1) begin $display("FAIL blink_minb got=%b exp=1", bus.min_blank); bad++; end
    total++; if (bus.sec_blank !== 1'b0) begin $display("FAIL blink_secb got=%b exp=0", bus.sec_blank); bad++; end
    total++; if (bus.mincount !== 6'd12) begin $display("FAIL blink_min_hold got=%0d exp=12", bus.mincount); bad++; end
    total++; if (bus.seccount !== 6'd5) begin $display("FAIL blink_sec got=%0d exp=5", bus.seccount); bad++; end
    frame(1, 2, 0, 5);
    total++; if (bus.frame_valid !== 1'b1) begin $display("FAIL unblink_valid got=%b exp=1", bus.frame_valid); bad++; end
    total++; if (bus.min_blank !== 1'b0) begin $display("FAIL unblink_minb got=%b exp=0", bus.min_blank); bad++; end
    total++; if (bus.mincount !== 6'd12) begin $display("FAIL unblink_min got=%0d exp=12", bus.mincount); bad++; end
  endtask

  task automatic test_out_of_order();
    step(0, seg_of(0));
    step(1, seg_of(0));
    step(3, seg_of(0));
    total++; if (bus.frame_err !== 1'b1) begin $display("FAIL ooo_err got=%b exp=1", bus.frame_err); bad++; end
    total++; if (bus.frame_valid !== 1'b0) begin $display("FAIL ooo_valid got=%b exp=0", bus.frame_valid); bad++; end
    total++; if (bus.err_count !== 8'd1) begin $display("FAIL ooo_errcnt got=%0d exp=1", bus.err_count); bad++; end
    frame(0, 0, 5, 9);
    total++; if (bus.frame_valid !== 1'b1) begin $display("FAIL ooo_next_valid got=%b exp=1", bus.frame_valid); bad++; end
    total++; if (bus.seccount !== 6'd59) begin $display("FAIL ooo_next_sec got=%0d exp=59", bus.seccount); bad++; end
    total++; if (bus.mincount !== 6'd0) begin $display("FAIL ooo_next_min got=%0d exp=0", bus.mincount); bad++; end
  endtask

  task automatic test_bad_patterns();
    step(0, seg_of(1));
    step(1, seg_of(2));
    step(-1, seg_of(3));
    total++; if (bus.frame_err !== 1'b1) begin $display("FAIL badan_err got=%b exp=1", bus.frame_err); bad++; end
    total++; if (bus.err_count !== 8'd2) begin $display("FAIL badan_errcnt got=%0d exp=2", bus.err_count); bad++; end
    step(0, seg_of(1));
    step(1, seg_of(2));
    step(2, 7'b1110000);
    total++; if (bus.frame_err !== 1'b1) begin $display("FAIL badseg_err got=%b exp=1", bus.frame_err); bad++; end
    total++; if (bus.err_count !== 8'd3) begin $display("FAIL badseg_errcnt got=%0d exp=3", bus.err_count); bad++; end
    frame(7, 2, 3, 4);
    total++; if ({bus.frame_valid, bus.frame_err} !== 2'b01) begin $display("FAIL range_pulses got=%b exp=01", {bus.frame_valid, bus.frame_err}); bad++; end
    total++; if (bus.mincount !== 6'd0) begin $display("FAIL range_min_hold got=%0d exp=0", bus.mincount); bad++; end
    total++; if (bus.seccount !== 6'd59) begin $display("FAIL range_sec_hold got=%0d exp=59", bus.seccount); bad++; end
    total++; if (bus.err_count !== 8'd4) begin $display("FAIL range_errcnt got=%0d exp=4", bus.err_count); bad++; end
    frame(10, 3, 3, 4);
    total++; if ({bus.frame_valid, bus.frame_err} !== 2'b01) begin $display("FAIL mixed_pulses got=%b exp=01", {bus.frame_valid, bus.frame_err}); bad++; end
    total++; if (bus.min_blank !== 1'b0) begin $display("FAIL mixed_minb got=%b exp=0", bus.min_blank); bad++; end
    total++; if (bus.err_count !== 8'd5) begin $display("FAIL mixed_errcnt got=%0d exp=5", bus.err_count); bad++; end
  endtask

  task automatic test_resync();
    step(0, seg_of(1));
    step(1, seg_of(2));
    step(0, seg_of(4));
    total++; if (bus.frame_err !== 1'b1) begin $display("FAIL resync_err got=%b exp=1", bus.frame_err); bad++; end
    total++; if (bus.err_count !== 8'd6) begin $display("FAIL resync_errcnt got=%0d exp=6", bus.err_count); bad++; end
    step(1, seg_of(5));
    total++; if ({bus.frame_valid, bus.frame_err} !== 2'b00) begin $display("FAIL resync_d1_pulses got=%b exp=00", {bus.frame_valid, bus.frame_err}); bad++; end
    step(2, seg_of(3));
    step(3, seg_of(2));
    total++; if (bus.frame_valid !== 1'b1) begin $display("FAIL resync_valid got=%b exp=1", bus.frame_valid); bad++; end
    total++; if (bus.mincount !== 6'd45) begin $display("FAIL resync_min got=%0d exp=45", bus.mincount); bad++; end
    total++; if (bus.seccount !== 6'd32) begin $display("FAIL resync_sec got=%0d exp=32", bus.seccount); bad++; end
  endtask

  task automatic test_reset_mid();
    step(0, seg_of(1));
    step(1, seg_of(2));
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.mincount, bus.seccount} !== 12'd0) begin $display("FAIL rstmid_counts got=%0d:%0d exp=0:0", bus.mincount, bus.seccount); bad++; end
    total++; if (bus.err_count !== 8'd0) begin $display("FAIL rstmid_errcnt got=%0d exp=0", bus.err_count); bad++; end
    @(posedge fastclk);
    #1;
    total++; if ({bus.frame_valid, bus.frame_err} !== 2'b00) begin $display("FAIL rstmid_pulses got=%b exp=00", {bus.frame_valid, bus.frame_err}); bad++; end
    rst_n = 1'b1;
    step(2, seg_of(3));
    step(3, seg_of(4));
    total++; if ({bus.frame_valid, bus.frame_err} !== 2'b00) begin $display("FAIL rstmid_partial got=%b exp=00", {bus.frame_valid, bus.frame_err}); bad++; end
    frame(2, 1, 4, 3);
    total++; if (bus.frame_valid !== 1'b1) begin $display("FAIL rstmid_after_valid got=%b exp=1", bus.frame_valid); bad++; end
    total++; if (bus.mincount !== 6'd21) begin $display("FAIL rstmid_after_min got=%0d exp=21", bus.mincount); bad++; end
    bus.anode = 4'b1111;
  endtask

  task automatic test_saturation();
    int exp;
    total++; if (bus_s.err_count !== 2'd0) begin $display("FAIL sat_start got=%0d exp=0", bus_s.err_count); bad++; end
    for (int k = 1; k <= 5; k++) begin
      step_s(0, seg_of(0));
      step_s(1, seg_of(0));
      step_s(3, seg_of(0));
      exp = (k < 3) ? k : 3;
      total++;
      if (bus_s.err_count !== exp[1:0]) begin $display("FAIL sat_count k=%0d got=%0d exp=%0d", k, bus_s.err_count, exp); bad++; end
    end
    bus_s.anode = 4'b1111;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_blink();
    test_out_of_order();
    test_bad_patterns();
    test_resync();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
